// File: rtl/tensor_smem_responder_pkg.sv
// Shared definitions for the tensor-core shared-memory responder:
// bus widths, request/response record layouts and address helpers.
package tensor_smem_responder_pkg;

    localparam int TC_SMEM_ADDR_WIDTH = 32;
    localparam int TC_SMEM_DATA_WIDTH = 256;
    localparam int TC_SMEM_TAG_WIDTH  = 4;

    typedef struct packed {
        logic [TC_SMEM_ADDR_WIDTH-1:0] addr;
        logic [TC_SMEM_TAG_WIDTH-1:0]  tag;
    } tc_smem_req_t;

    typedef struct packed {
        logic [TC_SMEM_DATA_WIDTH-1:0] data;
        logic [TC_SMEM_TAG_WIDTH-1:0]  tag;
    } tc_smem_rsp_t;

    // Number of byte-offset bits below the word index for a given word width.
    function automatic int offset_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/tensor_smem_rsp_fifo.sv
// Response FIFO with asynchronous active-low reset and a registered head entry,
// so the presented response comes straight from a flop and stays stable under stall.
module tensor_smem_rsp_fifo #(
    parameter int DATAW = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [DATAW-1:0]       push_data,
    input  logic                   pop,
    output logic [DATAW-1:0]       head_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH) + 1;

    logic [DATAW-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTRW-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNTW-1:0]  count_reg, count_next;
    logic [DATAW-1:0] head_reg, head_next;
    logic             do_push, do_pop;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] ptr);
        return (ptr == PTRW'(DEPTH - 1)) ? '0 : ptr + PTRW'(1);
    endfunction

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNTW'(DEPTH));
    assign count     = count_reg;
    assign head_data = head_reg;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        head_next   = head_reg;
        if (do_push) wr_ptr_next = ptr_inc(wr_ptr_reg);
        if (do_pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + CNTW'(1);
            2'b01:   count_next = count_reg - CNTW'(1);
            default: count_next = count_reg;
        endcase
        // Head refill: the next stored entry, or the entry arriving this cycle
        // when the FIFO is (or is about to become) otherwise empty.
        if (do_pop) begin
            if (count_reg > CNTW'(1)) head_next = mem[rd_ptr_next];
            else if (do_push)         head_next = push_data;
        end else if (do_push && empty) begin
            head_next = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
        end
    end

endmodule

// File: rtl/tensor_smem_responder.sv
// Shared-memory responder for one tensor-core operand port: fixed-latency bank
// read pipeline feeding a credit-bounded in-order response FIFO.
module tensor_smem_responder
    import tensor_smem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH   = TC_SMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH   = TC_SMEM_DATA_WIDTH,
    parameter int TAG_WIDTH    = TC_SMEM_TAG_WIDTH,
    parameter int NUM_WORDS    = 256,
    parameter int READ_LATENCY = 2,
    parameter int RSP_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic [TAG_WIDTH-1:0]         req_tag,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_WIDTH-1:0]        rsp_data,
    output logic [TAG_WIDTH-1:0]         rsp_tag,
    input  logic                         fill_valid,
    input  logic [$clog2(NUM_WORDS)-1:0] fill_idx,
    input  logic [DATA_WIDTH-1:0]        fill_data,
    output logic                         misalign_err,
    output logic [$clog2(RSP_DEPTH):0]   outstanding
);

    localparam int OFFSET_BITS = offset_bits(DATA_WIDTH);
    localparam int IDX_BITS    = $clog2(NUM_WORDS);
    localparam int CNTW        = $clog2(RSP_DEPTH) + 1;
    localparam int PIPE_STAGES = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;

    logic                  accept, pop;
    logic [IDX_BITS-1:0]   req_idx;
    logic                  addr_misaligned;
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic [TAG_WIDTH-1:0]  push_tag;
    logic [CNTW-1:0]       outstanding_reg, outstanding_next;
    logic                  misalign_reg, misalign_next;
    logic                  fifo_empty, fifo_full;
    logic [CNTW-1:0]       fifo_count;
    logic [TAG_WIDTH+DATA_WIDTH-1:0] fifo_head;

    logic [DATA_WIDTH-1:0] bank [NUM_WORDS];

    assign req_ready = (outstanding_reg < CNTW'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;
    assign req_idx   = req_addr[OFFSET_BITS +: IDX_BITS];

    if (OFFSET_BITS > 0) begin : g_offset
        assign addr_misaligned = |req_addr[OFFSET_BITS-1:0];
    end else begin : g_no_offset
        assign addr_misaligned = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (fill_valid) bank[fill_idx] <= fill_data;
    end

    // Stage 0 captures the bank read issued at acceptance, so a same-cycle
    // fill to the same word is seen only by later requests.
    if (READ_LATENCY == 1) begin : g_lat1
        assign push      = accept;
        assign push_data = bank[req_idx];
        assign push_tag  = req_tag;
    end else begin : g_latn
        for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
            logic                  vld_reg, vld_next;
            logic [TAG_WIDTH-1:0]  tag_reg, tag_next;
            logic [DATA_WIDTH-1:0] data_reg, data_next;

            if (gi == 0) begin : g_first
                assign vld_next  = accept;
                assign tag_next  = req_tag;
                assign data_next = bank[req_idx];
            end else begin : g_rest
                assign vld_next  = g_stage[gi-1].vld_reg;
                assign tag_next  = g_stage[gi-1].tag_reg;
                assign data_next = g_stage[gi-1].data_reg;
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_reg <= 1'b0;
                    tag_reg <= '0;
                end else begin
                    vld_reg <= vld_next;
                    tag_reg <= tag_next;
                end
            end

            always_ff @(posedge clk) begin
                data_reg <= data_next;
            end
        end
        assign push      = g_stage[PIPE_STAGES-1].vld_reg;
        assign push_data = g_stage[PIPE_STAGES-1].data_reg;
        assign push_tag  = g_stage[PIPE_STAGES-1].tag_reg;
    end

    tensor_smem_rsp_fifo #(
        .DATAW (TAG_WIDTH + DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({push_tag, push_data}),
        .pop       (pop),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign rsp_valid           = !fifo_empty;
    assign {rsp_tag, rsp_data} = fifo_head;

    always_comb begin
        outstanding_next = outstanding_reg;
        if (accept && !pop)      outstanding_next = outstanding_reg + CNTW'(1);
        else if (!accept && pop) outstanding_next = outstanding_reg - CNTW'(1);
        misalign_next = misalign_reg || (accept && addr_misaligned);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding_reg <= '0;
            misalign_reg    <= 1'b0;
        end else begin
            outstanding_reg <= outstanding_next;
            misalign_reg    <= misalign_next;
        end
    end

    assign outstanding  = outstanding_reg;
    assign misalign_err = misalign_reg;

    // Credit accounting makes FIFO overflow impossible; its flags are diagnostic only.
    logic unused_signals;
    assign unused_signals = ^{req_addr, fifo_full, fifo_count};

endmodule
